// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// The state names follow the frame layout: two header bytes, LEN, payload, CHK, then release.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        H0   = 3'd0,
        H1   = 3'd1,
        LEN  = 3'd2,
        PAY  = 3'd3,
        CHK  = 3'd4,
        EMIT = 3'd5
    } state_t;

    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;

    // States in which the inter-byte timeout counter is running.
    function automatic logic is_hunting(input state_t s);
        return (s == H1) || (s == LEN) || (s == PAY) || (s == CHK);
    endfunction

endpackage

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload buffer: DEPTH x 8 register file with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; the read data is only used while a verified frame is being emitted.
module frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: header hunt, length-prefixed payload capture, XOR check,
// then release of the verified payload over a valid/ready byte stream.
//
//   state | meaning
//   H0    | waiting for 0xAA
//   H1    | got 0xAA, waiting for 0x55 (0xAA again keeps us here)
//   LEN   | waiting for the length byte
//   PAY   | storing payload bytes into the buffer, accumulating XOR
//   CHK   | waiting for the checksum byte
//   EMIT  | streaming the buffered payload out; received bytes are dropped
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic [7:0] frm_data,
    output logic       frm_valid,
    output logic       frm_last,
    input  logic       frm_ready,
    output logic       frm_ok,
    output logic       chk_err,
    output logic       len_err,
    output logic       tmo_err,
    output logic       drop
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [LW-1:0] rd_q, rd_d;
    logic [7:0]    xor_q, xor_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          frm_ok_q, frm_ok_d;
    logic          chk_err_q, chk_err_d;
    logic          len_err_q, len_err_d;
    logic          tmo_err_q, tmo_err_d;
    logic          drop_q, drop_d;

    logic          wr_en;
    logic [7:0]    rd_data;
    logic          emitting;
    logic          rd_is_last;

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_frame_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (idx_q[AW-1:0]),
        .wdata (rx_byte),
        .raddr (rd_q[AW-1:0]),
        .rdata (rd_data)
    );

    assign emitting   = (state_q == EMIT);
    assign rd_is_last = (rd_q == len_q - LW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= H0;
            len_q     <= '0;
            idx_q     <= '0;
            rd_q      <= '0;
            xor_q     <= '0;
            tmo_q     <= '0;
            frm_ok_q  <= 1'b0;
            chk_err_q <= 1'b0;
            len_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            rd_q      <= rd_d;
            xor_q     <= xor_d;
            tmo_q     <= tmo_d;
            frm_ok_q  <= frm_ok_d;
            chk_err_q <= chk_err_d;
            len_err_q <= len_err_d;
            tmo_err_q <= tmo_err_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        xor_d     = xor_q;
        tmo_d     = tmo_q;
        frm_ok_d  = 1'b0;
        chk_err_d = 1'b0;
        len_err_d = 1'b0;
        tmo_err_d = 1'b0;
        drop_d    = 1'b0;
        wr_en     = 1'b0;

        // Any accepted byte restarts the inter-byte window; entry to a hunting state always comes with one.
        if (rx_ready && !emitting) begin
            tmo_d = TMO_LOAD;
        end

        case (state_q)
            H0: begin
                if (rx_ready && rx_byte == HDR0) begin
                    state_d = H1;
                end
            end
            H1: begin
                if (rx_ready) begin
                    if (rx_byte == HDR1) begin
                        state_d = LEN;
                    end else if (rx_byte == HDR0) begin
                        state_d = H1;
                    end else begin
                        state_d = H0;
                    end
                end
            end
            LEN: begin
                if (rx_ready) begin
                    if (rx_byte == 8'h00 || rx_byte > MAX_LEN_B) begin
                        len_err_d = 1'b1;
                        state_d   = H0;
                    end else begin
                        len_d   = rx_byte[LW-1:0];
                        xor_d   = rx_byte;
                        idx_d   = '0;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (rx_ready) begin
                    wr_en = 1'b1;
                    xor_d = xor_q ^ rx_byte;
                    idx_d = idx_q + LW'(1);
                    if (idx_q == len_q - LW'(1)) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_ready) begin
                    if (rx_byte == xor_q) begin
                        frm_ok_d = 1'b1;
                        rd_d     = '0;
                        state_d  = EMIT;
                    end else begin
                        chk_err_d = 1'b1;
                        state_d   = H0;
                    end
                end
            end
            EMIT: begin
                drop_d = rx_ready;
                if (frm_ready) begin
                    rd_d = rd_q + LW'(1);
                    if (rd_is_last) begin
                        state_d = H0;
                    end
                end
            end
            default: begin
                state_d = H0;
            end
        endcase

        // A byte arriving on the terminal count wins: the timeout only fires on an idle cycle.
        if (is_hunting(state_q) && !rx_ready) begin
            if (tmo_q == '0) begin
                tmo_err_d = 1'b1;
                state_d   = H0;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end
    end

    // Stream outputs come from registered state only; data is forced to zero outside EMIT.
    assign frm_valid = emitting;
    assign frm_data  = emitting ? rd_data : 8'h00;
    assign frm_last  = emitting && rd_is_last;

    assign frm_ok  = frm_ok_q;
    assign chk_err = chk_err_q;
    assign len_err = len_err_q;
    assign tmo_err = tmo_err_q;
    assign drop    = drop_q;

endmodule
